// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
package regfile_pkg;

    localparam int unsigned NREG_DEFAULT   = 16;
    localparam int unsigned PC_IDX_DEFAULT = 15;
    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned AW_DEFAULT     = $clog2(NREG_DEFAULT);

    typedef logic [AW_DEFAULT-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set from decode, cleared by writeback commits.
// A set and a clear to the same register on one edge leaves the bit set.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG   = NREG_DEFAULT,
    parameter int unsigned NRD    = 3,
    parameter int unsigned PC_IDX = PC_IDX_DEFAULT,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_en0,
    input  logic [AW-1:0]           clr_addr0,
    input  logic                    clr_en1,
    input  logic [AW-1:0]           clr_addr1,
    input  logic                    set_en,
    input  logic [AW-1:0]           set_addr,
    input  logic [NRD-1:0][AW-1:0]  lk_addr,
    output logic [NRD-1:0]          lk_busy
);

    localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

    logic [NREG-1:0] pend_q, pend_d;

    // Next pending state: clears first, then set so it takes precedence.
    always_comb begin
        pend_d = pend_q;
        if (clr_en0) pend_d[clr_addr0] = 1'b0;
        if (clr_en1) pend_d[clr_addr1] = 1'b0;
        if (set_en && (set_addr != PC_A)) pend_d[set_addr] = 1'b1;
    end

    // Pending bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    // Lookups see the pre-update value; the PC never reports busy.
    for (genvar i = 0; i < NRD; i++) begin : g_lk
        assign lk_busy[i] = (lk_addr[i] == PC_A) ? 1'b0 : pend_q[lk_addr[i]];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads with PC substitution,
// two prioritised write ports, optional write-through bypass and a
// pending-register scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned NREG   = NREG_DEFAULT,
    parameter int unsigned NRD    = 3,
    parameter int unsigned PC_IDX = PC_IDX_DEFAULT,
    parameter bit          BYPASS = 1'b1,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NRD-1:0][AW-1:0]     ra,
    output logic [NRD-1:0][DATA_W-1:0] rd,
    output logic [NRD-1:0]             rd_busy,
    input  logic [DATA_W-1:0]          pc_in,
    input  logic                       we0,
    input  logic [AW-1:0]              wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic                       we1,
    input  logic [AW-1:0]              wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic                       sb_set,
    input  logic [AW-1:0]              sb_addr,
    output logic                       pc_wr_valid,
    output logic [DATA_W-1:0]          pc_wr_data,
    output logic                       wr_collide
);

    localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

    // The PC entry is never written, so it stays a constant zero.
    logic [DATA_W-1:0] mem [NREG];

    logic              same_addr;
    logic              commit0, commit1;
    logic              pc_hit0, pc_hit1;
    logic              pc_wr_valid_d, wr_collide_d;
    logic [DATA_W-1:0] pc_wr_data_d;

    // Commit decode: port 0 wins a same-register collision, PC is never stored.
    always_comb begin
        same_addr     = we0 && we1 && (wa0 == wa1);
        pc_hit0       = we0 && (wa0 == PC_A);
        pc_hit1       = we1 && (wa1 == PC_A);
        commit0       = we0 && !pc_hit0;
        commit1       = we1 && !pc_hit1 && !same_addr;
        wr_collide_d  = same_addr;
        pc_wr_valid_d = pc_hit0 || pc_hit1;
        pc_wr_data_d  = pc_wr_data;
        if (pc_hit0)      pc_wr_data_d = wd0;
        else if (pc_hit1) pc_wr_data_d = wd1;
    end

    // Register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) mem[r] <= '0;
        end else begin
            if (commit0) mem[wa0] <= wd0;
            if (commit1) mem[wa1] <= wd1;
        end
    end

    // Single-cycle status pulses and the captured PC write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_wr_valid <= 1'b0;
            pc_wr_data  <= '0;
            wr_collide  <= 1'b0;
        end else begin
            pc_wr_valid <= pc_wr_valid_d;
            pc_wr_data  <= pc_wr_data_d;
            wr_collide  <= wr_collide_d;
        end
    end

    // Read muxes: PC substitution, then optional bypass, then storage.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic hit0, hit1;
        assign hit0  = BYPASS && we0 && (wa0 == ra[i]);
        assign hit1  = BYPASS && we1 && (wa1 == ra[i]);
        assign rd[i] = (ra[i] == PC_A) ? pc_in :
                       hit0            ? wd0   :
                       hit1            ? wd1   : mem[ra[i]];
    end

    regfile_scoreboard #(
        .NREG   (NREG),
        .NRD    (NRD),
        .PC_IDX (PC_IDX)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_en0   (commit0),
        .clr_addr0 (wa0),
        .clr_en1   (commit1),
        .clr_addr1 (wa1),
        .set_en    (sb_set),
        .set_addr  (sb_addr),
        .lk_addr   (ra),
        .lk_busy   (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing
// instance share all inputs.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0][3:0]  ra;
    logic [2:0][31:0] rd_b, rd_n;
    logic [2:0]       busy_b, busy_n;
    logic [31:0]      pc_in;
    logic             we0, we1, sb_set;
    logic [3:0]       wa0, wa1, sb_addr;
    logic [31:0]      wd0, wd1;
    logic             pcv_b, pcv_n, col_b, col_n;
    logic [31:0]      pcd_b, pcd_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_b), .rd_busy(busy_b), .pc_in(pc_in),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .sb_set(sb_set), .sb_addr(sb_addr), .pc_wr_valid(pcv_b), .pc_wr_data(pcd_b),
        .wr_collide(col_b)
    );

    regfile_mp #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_n), .rd_busy(busy_n), .pc_in(pc_in),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .sb_set(sb_set), .sb_addr(sb_addr), .pc_wr_valid(pcv_n), .pc_wr_data(pcd_n),
        .wr_collide(col_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; sb_set = 1'b0;
    endtask

    initial begin
        reg_addr_t a;
        rst_n = 1'b0; ra = '0; pc_in = 32'h0000_1008;
        we0 = 1'b0; wa0 = '0; wd0 = '0; we1 = 1'b0; wa1 = '0; wd1 = '0;
        sb_set = 1'b0; sb_addr = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_pcv", {31'd0, pcv_b}, 32'd0);
        chk("rst_pcd", pcd_b, 32'd0);
        chk("rst_col", {31'd0, col_b}, 32'd0);
        for (int i = 0; i < 15; i++) begin
            a = reg_addr_t'(i);
            ra = {a, a, a};
            #1;
            chk($sformatf("rst_rd0_r%0d", i), rd_b[0], 32'd0);
            chk($sformatf("rst_rd2_r%0d", i), rd_n[2], 32'd0);
            chk($sformatf("rst_busy_r%0d", i), {29'd0, busy_b}, 32'd0);
        end
        ra = {4'd15, 4'd15, 4'd15};
        #1;
        chk("rst_pc_rd0", rd_b[0], 32'h0000_1008);
        chk("rst_pc_rd1", rd_n[1], 32'h0000_1008);
        chk("rst_pc_busy", {29'd0, busy_b}, 32'd0);

        // Bypass vs no bypass
        tick();
        we0 = 1'b1; wa0 = 4'd3; wd0 = 32'hDEAD_BEEF; ra[0] = 4'd3;
        #1;
        chk("byp_same", rd_b[0], 32'hDEAD_BEEF);
        chk("nobyp_same", rd_n[0], 32'd0);
        tick(); idle();
        #1;
        chk("byp_next", rd_b[0], 32'hDEAD_BEEF);
        chk("nobyp_next", rd_n[0], 32'hDEAD_BEEF);

        // Same-register collision: port 0 wins
        we0 = 1'b1; wa0 = 4'd5; wd0 = 32'h11; we1 = 1'b1; wa1 = 4'd5; wd1 = 32'h22;
        ra[0] = 4'd5;
        #1;
        chk("col_byp_same", rd_b[0], 32'h11);
        tick(); idle();
        #1;
        chk("col_r5", rd_n[0], 32'h11);
        chk("col_pulse", {31'd0, col_b}, 32'd1);
        chk("col_pcv", {31'd0, pcv_b}, 32'd0);
        // Different registers both commit
        we0 = 1'b1; wa0 = 4'd5; wd0 = 32'h55; we1 = 1'b1; wa1 = 4'd6; wd1 = 32'h66;
        ra[1] = 4'd6;
        #1;
        chk("dual_byp_r6", rd_b[1], 32'h66);
        tick(); idle();
        #1;
        chk("dual_col", {31'd0, col_n}, 32'd0);
        chk("dual_r5", rd_n[0], 32'h55);
        chk("dual_r6", rd_n[1], 32'h66);
        chk("dual_r5_b", rd_b[0], 32'h55);

        // PC write
        we1 = 1'b1; wa1 = 4'd15; wd1 = 32'h0000_2000; ra[0] = 4'd15;
        #1;
        chk("pcw_rd_same", rd_b[0], 32'h0000_1008);
        tick(); idle();
        #1;
        chk("pcw_valid", {31'd0, pcv_b}, 32'd1);
        chk("pcw_data", pcd_n, 32'h0000_2000);
        chk("pcw_rd", rd_n[0], 32'h0000_1008);
        tick();
        chk("pcw_pulse_end", {31'd0, pcv_b}, 32'd0);

        // Scoreboard
        sb_set = 1'b1; sb_addr = 4'd7; ra[2] = 4'd7;
        #1;
        chk("sb_pre", {31'd0, busy_b[2]}, 32'd0);
        tick(); idle();
        #1;
        chk("sb_set", {31'd0, busy_b[2]}, 32'd1);
        we1 = 1'b1; wa1 = 4'd7; wd1 = 32'h77; sb_set = 1'b1; sb_addr = 4'd7;
        tick(); idle();
        #1;
        chk("sb_set_wins", {31'd0, busy_n[2]}, 32'd1);
        chk("sb_r7_data", rd_n[2], 32'h77);
        we0 = 1'b1; wa0 = 4'd7; wd0 = 32'h70;
        #1;
        chk("sb_clr_pre", {31'd0, busy_b[2]}, 32'd1);
        tick(); idle();
        #1;
        chk("sb_clr", {31'd0, busy_b[2]}, 32'd0);
        chk("sb_r7_new", rd_n[2], 32'h70);
        sb_set = 1'b1; sb_addr = 4'd15;
        tick(); idle();
        ra[2] = 4'd15;
        #1;
        chk("sb_pc_ignored", {31'd0, busy_b[2]}, 32'd0);

        // Asynchronous reset mid-cycle
        sb_set = 1'b1; sb_addr = 4'd9;
        we0 = 1'b1; wa0 = 4'd10; wd0 = 32'hAA;
        we1 = 1'b1; wa1 = 4'd15; wd1 = 32'h3000;
        tick(); idle();
        ra = {4'd3, 4'd10, 4'd9};
        #1;
        chk("pre_rst_busy9", {31'd0, busy_b[0]}, 32'd1);
        chk("pre_rst_r10", rd_n[1], 32'hAA);
        chk("pre_rst_pcv", {31'd0, pcv_b}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pcv", {31'd0, pcv_b}, 32'd0);
        chk("arst_pcd", pcd_b, 32'd0);
        chk("arst_col", {31'd0, col_n}, 32'd0);
        chk("arst_busy", {29'd0, busy_b}, 32'd0);
        chk("arst_r9", rd_n[0], 32'd0);
        chk("arst_r10", rd_n[1], 32'd0);
        chk("arst_r3", rd_b[2], 32'd0);
        // Edge while reset held must not write
        we0 = 1'b1; wa0 = 4'd4; wd0 = 32'h44; sb_set = 1'b1; sb_addr = 4'd4;
        tick(); idle();
        ra[0] = 4'd4;
        #1;
        chk("arst_edge_r4", rd_b[0], 32'd0);
        chk("arst_edge_busy4", {31'd0, busy_b[0]}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_r4", rd_n[0], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the next-generation ARM core, replacing the fixed 2R+1W file. Provides NRD combinational read ports with PC substitution on register 15, two prioritised write ports (result + base/load writeback), optional same-cycle write-through bypass, and a per-register pending scoreboard for load-use and multi-cycle hazards. Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

## Interface

- DATA_W, 32, register width
- NREG, 16, architectural registers (power of two, ≥ 2)
- NRD, 3, read ports (port 2 serves register-shifted-register Rs)
- PC_IDX, 15, index that reads return `pc_in` for and that is never stored
- BYPASS, 1, 1 = read of a register written this cycle returns the write data
- AW, $clog2(NREG), derived address width (localparam)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ra  in  NRD×AW  read addresses
- rd  out  NRD×DATA_W  read data
- rd_busy  out  NRD  pending bit of the addressed register
- pc_in  in  DATA_W  value returned for PC_IDX reads (PC+8)
- we0, wa0, wd0  in  1/AW/DATA_W  write port 0 (ALU result, higher priority)
- we1, wa1, wd1  in  1/AW/DATA_W  write port 1 (load data / base writeback)
- sb_set, sb_addr  in  1/AW  mark register pending
- pc_wr_valid  out  1  registered: a write targeted PC_IDX last cycle
- pc_wr_data  out  DATA_W  registered data of that write
- wr_collide  out  1  registered: both ports wrote the same register last cycle

## Operation

- Storage: NREG−1 words (PC_IDX excluded); all cleared to 0 on reset.
- Read port i: ra[i]==PC_IDX → pc_in; else if BYPASS and a same-cycle write hits ra[i] → winning write data; else stored value. rd_busy[i] = 0 for PC_IDX, else pending[ra[i]] (pre-update value).
- Write: we0 and we1 to different registers both commit. Same register: port 0 data commits, wr_collide=1 next cycle.
- Write to PC_IDX: not stored; pc_wr_valid=1, pc_wr_data=winning data next cycle. Otherwise pc_wr_valid=0 (single-cycle pulse).
- Scoreboard: any commit to register r clears pending[r] at the edge; sb_set sets pending[sb_addr]. Same register, same edge: set wins (pending stays 1). sb_set with sb_addr==PC_IDX ignored.

## Timing

- Reads combinational, zero latency; writes and scoreboard update on rising clk.
- Reset (asynchronous assert, any time, including mid-write): registers 0, pending all 0, pc_wr_valid 0, pc_wr_data 0, wr_collide 0. An edge coinciding with rst_n low has no effect.
- Write visible on reads: same cycle with BYPASS=1, next cycle with BYPASS=0.
- pc_wr_valid and wr_collide: exactly one cycle after the causing edge, low otherwise.

## Structure

- Package regfile_pkg: NREG_DEFAULT, PC_IDX_DEFAULT, DATA_W_DEFAULT, and typedef reg_addr_t (logic [AW-1:0]).
- Sub-module regfile_scoreboard: NREG pending bits, set/clear ports, asynchronous reset, combinational NRD lookups.
- Read muxes via generate loop over NRD.

## Test plan

- Reset, then read all ra=0..14 → rd=0, rd_busy=0; ra=15 with pc_in=0x0000_1008 → 0x0000_1008.
- we0 wa0=3 wd0=0xDEAD_BEEF, ra[0]=3 same cycle → 0xDEAD_BEEF with BYPASS=1, old value 0 with BYPASS=0; next cycle 0xDEAD_BEEF either way.
- we0 and we1 both to r5 (0x11, 0x22) → r5=0x11, wr_collide=1 one cycle; to r5/r6 → both stored, wr_collide=0.
- we1 wa1=15 wd1=0x0000_2000 → pc_wr_valid=1, pc_wr_data=0x0000_2000 next cycle only; ra=15 still returns pc_in.
- sb_set r7 → rd_busy=1 next cycle; we1 r7 plus sb_set r7 same edge → stays 1; we0 r7 alone → 0.
- Assert rst_n low mid-cycle after writes and sb_set → all outputs/registers 0 immediately, pending cleared.
